// File: rtl/nvdla_dmaif_pkg.sv
// Shared types and defaults for the RDMA read DMA interface.
package nvdla_dmaif_pkg;

    localparam logic RAM_TYPE_MCIF = 1'b1;
    localparam logic RAM_TYPE_CVIF = 1'b0;

    localparam int DEF_REQ_PD_W = 79;
    localparam int DEF_RSP_PD_W = 257;

endpackage

// File: rtl/nvdla_dmaif_pipe.sv
// One-entry valid/ready register slice.
import nvdla_dmaif_pkg::*;

module nvdla_dmaif_pipe #(
    parameter int W = 8
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_pd,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_pd
);

    logic         full;
    logic [W-1:0] data;

    assign in_rdy  = !full | out_rdy;
    assign out_vld = full;
    assign out_pd  = data;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            full <= 1'b0;
            data <= '0;
        end else if (in_vld && in_rdy) begin
            full <= 1'b1;
            data <= in_pd;
        end else if (out_rdy) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/nvdla_dmaif_rd_tracker.sv
// Read DMA steering to MCIF/CVIF with in-order merge and
// latency-FIFO credit tracking.
import nvdla_dmaif_pkg::*;

module nvdla_dmaif_rd_tracker #(
    parameter int REQ_PD_W  = DEF_REQ_PD_W,
    parameter int RSP_PD_W  = DEF_RSP_PD_W,
    parameter int LAT_DEPTH = 64,
    parameter int PTR_W     = $clog2(LAT_DEPTH)
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic                dma_rd_req_vld,
    output logic                dma_rd_req_rdy,
    input  logic [REQ_PD_W-1:0] dma_rd_req_pd,
    input  logic                dma_rd_req_ram_type,
    output logic                dma_rd_rsp_vld,
    input  logic                dma_rd_rsp_rdy,
    output logic [RSP_PD_W-1:0] dma_rd_rsp_pd,
    input  logic                dma_rd_cdt_lat_fifo_pop,
    output logic                sdp2mcif_rd_req_valid,
    input  logic                sdp2mcif_rd_req_ready,
    output logic [REQ_PD_W-1:0] sdp2mcif_rd_req_pd,
    input  logic                mcif2sdp_rd_rsp_valid,
    output logic                mcif2sdp_rd_rsp_ready,
    input  logic [RSP_PD_W-1:0] mcif2sdp_rd_rsp_pd,
    output logic                sdp2mcif_rd_cdt_lat_fifo_pop,
    output logic                sdp2cvif_rd_req_valid,
    input  logic                sdp2cvif_rd_req_ready,
    output logic [REQ_PD_W-1:0] sdp2cvif_rd_req_pd,
    input  logic                cvif2sdp_rd_rsp_valid,
    output logic                cvif2sdp_rd_rsp_ready,
    input  logic [RSP_PD_W-1:0] cvif2sdp_rd_rsp_pd,
    output logic                sdp2cvif_rd_cdt_lat_fifo_pop,
    output logic [PTR_W:0]      dma_rd_outstanding,
    output logic                dma_rd_err
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    logic [LAT_DEPTH-1:0] ring;
    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rsp_ptr;
    logic [PTR_W:0]       pop_ptr;
    logic                 live;

    logic                lat_full;
    logic                req_cap;
    logic                req_in_rdy;
    logic                req_acc;
    logic                req_q_vld;
    logic                req_q_type;
    logic [REQ_PD_W-1:0] req_q_pd;
    logic                sel_ready;

    assign lat_full = (wr_ptr[PTR_W] != pop_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == pop_ptr[PTR_W-1:0]);
    assign req_cap  = live & !lat_full;
    assign dma_rd_req_rdy = req_in_rdy & req_cap;
    assign req_acc  = dma_rd_req_vld & dma_rd_req_rdy;

    assign sel_ready = (req_q_type == RAM_TYPE_MCIF) ?
                       sdp2mcif_rd_req_ready : sdp2cvif_rd_req_ready;

    nvdla_dmaif_pipe #(.W(REQ_PD_W + 1)) u_req_pipe (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .in_vld          (dma_rd_req_vld & req_cap),
        .in_rdy          (req_in_rdy),
        .in_pd           ({dma_rd_req_ram_type, dma_rd_req_pd}),
        .out_vld         (req_q_vld),
        .out_rdy         (sel_ready),
        .out_pd          ({req_q_type, req_q_pd})
    );

    assign sdp2mcif_rd_req_valid = req_q_vld & (req_q_type == RAM_TYPE_MCIF);
    assign sdp2cvif_rd_req_valid = req_q_vld & (req_q_type == RAM_TYPE_CVIF);
    assign sdp2mcif_rd_req_pd    = req_q_pd;
    assign sdp2cvif_rd_req_pd    = req_q_pd;

    // The entry sitting in the response slice is still counted at rsp_ptr,
    // so the next port accept looks one slot further.
    logic [PTR_W:0]      acc_ptr;
    logic                acc_pend;
    logic                acc_type;
    logic                rsp_in_rdy;
    logic                rsp_in_vld;
    logic [RSP_PD_W-1:0] rsp_in_pd;
    logic                rsp_hs;

    assign acc_ptr  = rsp_ptr + {{PTR_W{1'b0}}, dma_rd_rsp_vld};
    assign acc_pend = (acc_ptr != wr_ptr);
    assign acc_type = ring[acc_ptr[PTR_W-1:0]];

    assign mcif2sdp_rd_rsp_ready = rsp_in_rdy & acc_pend &
                                   (acc_type == RAM_TYPE_MCIF);
    assign cvif2sdp_rd_rsp_ready = rsp_in_rdy & acc_pend &
                                   (acc_type == RAM_TYPE_CVIF);

    assign rsp_in_vld = (mcif2sdp_rd_rsp_valid & mcif2sdp_rd_rsp_ready) |
                        (cvif2sdp_rd_rsp_valid & cvif2sdp_rd_rsp_ready);
    assign rsp_in_pd  = (acc_type == RAM_TYPE_MCIF) ?
                        mcif2sdp_rd_rsp_pd : cvif2sdp_rd_rsp_pd;

    nvdla_dmaif_pipe #(.W(RSP_PD_W)) u_rsp_pipe (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .in_vld          (rsp_in_vld),
        .in_rdy          (rsp_in_rdy),
        .in_pd           (rsp_in_pd),
        .out_vld         (dma_rd_rsp_vld),
        .out_rdy         (dma_rd_rsp_rdy),
        .out_pd          (dma_rd_rsp_pd)
    );

    assign rsp_hs = dma_rd_rsp_vld & dma_rd_rsp_rdy;
    assign dma_rd_outstanding = wr_ptr - pop_ptr;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ring    <= '0;
            wr_ptr  <= '0;
            rsp_ptr <= '0;
            pop_ptr <= '0;
            live    <= 1'b0;
            dma_rd_err <= 1'b0;
            sdp2mcif_rd_cdt_lat_fifo_pop <= 1'b0;
            sdp2cvif_rd_cdt_lat_fifo_pop <= 1'b0;
        end else begin
            live <= 1'b1;
            sdp2mcif_rd_cdt_lat_fifo_pop <= 1'b0;
            sdp2cvif_rd_cdt_lat_fifo_pop <= 1'b0;
            if (req_acc) begin
                ring[wr_ptr[PTR_W-1:0]] <= dma_rd_req_ram_type;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rsp_hs) begin
                rsp_ptr <= rsp_ptr + PTR_ONE;
            end
            if (dma_rd_cdt_lat_fifo_pop) begin
                if (pop_ptr != rsp_ptr) begin
                    pop_ptr <= pop_ptr + PTR_ONE;
                    sdp2mcif_rd_cdt_lat_fifo_pop <=
                        (ring[pop_ptr[PTR_W-1:0]] == RAM_TYPE_MCIF);
                    sdp2cvif_rd_cdt_lat_fifo_pop <=
                        (ring[pop_ptr[PTR_W-1:0]] == RAM_TYPE_CVIF);
                end else begin
                    dma_rd_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nvdla_dmaif_rd_tracker.sv
// Randomized bench for nvdla_dmaif_rd_tracker against an
// in-order queue model of requests, responses and credits.
module tb_nvdla_dmaif_rd_tracker;

    localparam int RQW = 79;
    localparam int RSW = 257;
    localparam int LD  = 4;
    localparam int PW  = 2;

    logic           nvdla_core_clk = 1'b0;
    logic           nvdla_core_rstn = 1'b0;
    logic           dma_rd_req_vld = 1'b0;
    logic           dma_rd_req_rdy;
    logic [RQW-1:0] dma_rd_req_pd = '0;
    logic           dma_rd_req_ram_type = 1'b0;
    logic           dma_rd_rsp_vld;
    logic           dma_rd_rsp_rdy = 1'b1;
    logic [RSW-1:0] dma_rd_rsp_pd;
    logic           dma_rd_cdt_lat_fifo_pop = 1'b0;
    logic           sdp2mcif_rd_req_valid;
    logic           sdp2mcif_rd_req_ready = 1'b1;
    logic [RQW-1:0] sdp2mcif_rd_req_pd;
    logic           mcif2sdp_rd_rsp_valid = 1'b0;
    logic           mcif2sdp_rd_rsp_ready;
    logic [RSW-1:0] mcif2sdp_rd_rsp_pd = '0;
    logic           sdp2mcif_rd_cdt_lat_fifo_pop;
    logic           sdp2cvif_rd_req_valid;
    logic           sdp2cvif_rd_req_ready = 1'b1;
    logic [RQW-1:0] sdp2cvif_rd_req_pd;
    logic           cvif2sdp_rd_rsp_valid = 1'b0;
    logic           cvif2sdp_rd_rsp_ready;
    logic [RSW-1:0] cvif2sdp_rd_rsp_pd = '0;
    logic           sdp2cvif_rd_cdt_lat_fifo_pop;
    logic [PW:0]    dma_rd_outstanding;
    logic           dma_rd_err;

    nvdla_dmaif_rd_tracker #(
        .REQ_PD_W  (RQW),
        .RSP_PD_W  (RSW),
        .LAT_DEPTH (LD)
    ) dut (
        .nvdla_core_clk               (nvdla_core_clk),
        .nvdla_core_rstn              (nvdla_core_rstn),
        .dma_rd_req_vld               (dma_rd_req_vld),
        .dma_rd_req_rdy               (dma_rd_req_rdy),
        .dma_rd_req_pd                (dma_rd_req_pd),
        .dma_rd_req_ram_type          (dma_rd_req_ram_type),
        .dma_rd_rsp_vld               (dma_rd_rsp_vld),
        .dma_rd_rsp_rdy               (dma_rd_rsp_rdy),
        .dma_rd_rsp_pd                (dma_rd_rsp_pd),
        .dma_rd_cdt_lat_fifo_pop      (dma_rd_cdt_lat_fifo_pop),
        .sdp2mcif_rd_req_valid        (sdp2mcif_rd_req_valid),
        .sdp2mcif_rd_req_ready        (sdp2mcif_rd_req_ready),
        .sdp2mcif_rd_req_pd           (sdp2mcif_rd_req_pd),
        .mcif2sdp_rd_rsp_valid        (mcif2sdp_rd_rsp_valid),
        .mcif2sdp_rd_rsp_ready        (mcif2sdp_rd_rsp_ready),
        .mcif2sdp_rd_rsp_pd           (mcif2sdp_rd_rsp_pd),
        .sdp2mcif_rd_cdt_lat_fifo_pop (sdp2mcif_rd_cdt_lat_fifo_pop),
        .sdp2cvif_rd_req_valid        (sdp2cvif_rd_req_valid),
        .sdp2cvif_rd_req_ready        (sdp2cvif_rd_req_ready),
        .sdp2cvif_rd_req_pd           (sdp2cvif_rd_req_pd),
        .cvif2sdp_rd_rsp_valid        (cvif2sdp_rd_rsp_valid),
        .cvif2sdp_rd_rsp_ready        (cvif2sdp_rd_rsp_ready),
        .cvif2sdp_rd_rsp_pd           (cvif2sdp_rd_rsp_pd),
        .sdp2cvif_rd_cdt_lat_fifo_pop (sdp2cvif_rd_cdt_lat_fifo_pop),
        .dma_rd_outstanding           (dma_rd_outstanding),
        .dma_rd_err                   (dma_rd_err)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    int errs   = 0;
    int checks = 0;

    // Model: types issued but not yet given responses, client
    // response order, per-port supply queues, delivered-unpopped types.
    bit             issued_q[$];
    logic [RSW-1:0] exp_q[$];
    logic [RSW-1:0] m_q[$];
    logic [RSW-1:0] c_q[$];
    bit             del_q[$];
    int             model_out = 0;

    function automatic logic [RQW-1:0] rand_req();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[RQW-1:0];
    endfunction

    function automatic logic [RSW-1:0] rand_rsp();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
        return t[RSW-1:0];
    endfunction

    task automatic step();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic clear_model();
        issued_q.delete();
        exp_q.delete();
        m_q.delete();
        c_q.delete();
        del_q.delete();
        model_out = 0;
    endtask

    task automatic check_idle(input string nm);
        checks++;
        if (sdp2mcif_rd_req_valid !== 1'b0 || sdp2cvif_rd_req_valid !== 1'b0 ||
            dma_rd_rsp_vld !== 1'b0 || mcif2sdp_rd_rsp_ready !== 1'b0 ||
            cvif2sdp_rd_rsp_ready !== 1'b0 ||
            sdp2mcif_rd_cdt_lat_fifo_pop !== 1'b0 ||
            sdp2cvif_rd_cdt_lat_fifo_pop !== 1'b0 ||
            dma_rd_err !== 1'b0 || dma_rd_outstanding !== '0 ||
            dma_rd_req_rdy !== 1'b0)
            begin
            errs++;
            $display("FAIL %s: vm=%b vc=%b rv=%b rm=%b rc=%b pm=%b pc=%b err=%b out=%0d rdy=%b want all 0",
                nm, sdp2mcif_rd_req_valid, sdp2cvif_rd_req_valid,
                dma_rd_rsp_vld, mcif2sdp_rd_rsp_ready,
                cvif2sdp_rd_rsp_ready, sdp2mcif_rd_cdt_lat_fifo_pop,
                sdp2cvif_rd_cdt_lat_fifo_pop, dma_rd_err,
                dma_rd_outstanding, dma_rd_req_rdy);
        end
    endtask

    task automatic issue(input bit t);
        logic [RQW-1:0] d;
        int n;
        d = rand_req();
        dma_rd_req_vld = 1'b1;
        dma_rd_req_pd = d;
        dma_rd_req_ram_type = t;
        n = 0;
        while (!dma_rd_req_rdy && n < 50) begin
            step();
            n++;
        end
        step();
        dma_rd_req_vld = 1'b0;
        issued_q.push_back(t);
        model_out++;
        checks++;
        if (n >= 50) begin
            errs++;
            $display("FAIL issue_timeout: rdy=%b required 1", dma_rd_req_rdy);
        end
        checks++;
        if ((t ? sdp2mcif_rd_req_valid : sdp2cvif_rd_req_valid) !== 1'b1 ||
            (t ? sdp2cvif_rd_req_valid : sdp2mcif_rd_req_valid) !== 1'b0 ||
            (t ? sdp2mcif_rd_req_pd : sdp2cvif_rd_req_pd) !== d) begin
            errs++;
            $display("FAIL issue_route type=%0b: vm=%b vc=%b pm=%h pc=%h required pd %h",
                t, sdp2mcif_rd_req_valid, sdp2cvif_rd_req_valid,
                sdp2mcif_rd_req_pd, sdp2cvif_rd_req_pd, d);
        end
        checks++;
        if (dma_rd_outstanding !== (PW+1)'(model_out)) begin
            errs++;
            $display("FAIL issue_outstanding: got %0d required %0d",
                dma_rd_outstanding, model_out);
        end
    endtask

    // Supply responses for everything issued; MCIF data may be held back
    // for m_delay cycles to force out-of-order arrival.
    task automatic respond_all(input int m_delay);
        logic [RSW-1:0] d;
        int cyc;
        bit mhs, chs;
        foreach (issued_q[i]) begin
            d = rand_rsp();
            exp_q.push_back(d);
            del_q.push_back(issued_q[i]);
            if (issued_q[i]) m_q.push_back(d);
            else c_q.push_back(d);
        end
        issued_q.delete();
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 300) begin
            mcif2sdp_rd_rsp_valid = (m_q.size() > 0) && (cyc >= m_delay);
            if (m_q.size() > 0) mcif2sdp_rd_rsp_pd = m_q[0];
            cvif2sdp_rd_rsp_valid = (c_q.size() > 0);
            if (c_q.size() > 0) cvif2sdp_rd_rsp_pd = c_q[0];
            dma_rd_rsp_rdy = (m_delay > 0) || ($urandom_range(0, 3) != 0);
            #1;
            if (cyc < m_delay) begin
                checks++;
                if (cvif2sdp_rd_rsp_ready !== 1'b0 || dma_rd_rsp_vld !== 1'b0) begin
                    errs++;
                    $display("FAIL ooo_hold: cvif_ready=%b rsp_vld=%b required 0 0",
                        cvif2sdp_rd_rsp_ready, dma_rd_rsp_vld);
                end
            end
            checks++;
            if (mcif2sdp_rd_rsp_ready === 1'b1 && cvif2sdp_rd_rsp_ready === 1'b1) begin
                errs++;
                $display("FAIL rsp_ready_excl: both port readies high, required at most one");
            end
            if (dma_rd_rsp_vld === 1'b1 && dma_rd_rsp_rdy) begin
                checks++;
                if (dma_rd_rsp_pd !== exp_q[0]) begin
                    errs++;
                    $display("FAIL rsp_order: got %h required %h",
                        dma_rd_rsp_pd, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            mhs = mcif2sdp_rd_rsp_valid && mcif2sdp_rd_rsp_ready;
            chs = cvif2sdp_rd_rsp_valid && cvif2sdp_rd_rsp_ready;
            @(posedge nvdla_core_clk);
            #1;
            if (mhs) void'(m_q.pop_front());
            if (chs) void'(c_q.pop_front());
            cyc++;
        end
        mcif2sdp_rd_rsp_valid = 1'b0;
        cvif2sdp_rd_rsp_valid = 1'b0;
        dma_rd_rsp_rdy = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL rsp_timeout: %0d responses undelivered required 0",
                exp_q.size());
            exp_q.delete();
            m_q.delete();
            c_q.delete();
        end
    endtask

    task automatic pop_one(input bit t);
        dma_rd_cdt_lat_fifo_pop = 1'b1;
        step();
        dma_rd_cdt_lat_fifo_pop = 1'b0;
        model_out--;
        checks++;
        if (sdp2mcif_rd_cdt_lat_fifo_pop !== t ||
            sdp2cvif_rd_cdt_lat_fifo_pop !== !t) begin
            errs++;
            $display("FAIL pop_route type=%0b: pm=%b pc=%b required %b %b",
                t, sdp2mcif_rd_cdt_lat_fifo_pop,
                sdp2cvif_rd_cdt_lat_fifo_pop, t, !t);
        end
    endtask

    task automatic pop_all();
        while (del_q.size() > 0) begin
            repeat ($urandom_range(0, 2)) step();
            pop_one(del_q.pop_front());
        end
        step();
        checks++;
        if (dma_rd_outstanding !== (PW+1)'(model_out) ||
            sdp2mcif_rd_cdt_lat_fifo_pop !== 1'b0 ||
            sdp2cvif_rd_cdt_lat_fifo_pop !== 1'b0) begin
            errs++;
            $display("FAIL pop_drain: out=%0d pm=%b pc=%b required %0d 0 0",
                dma_rd_outstanding, sdp2mcif_rd_cdt_lat_fifo_pop,
                sdp2cvif_rd_cdt_lat_fifo_pop, model_out);
        end
    endtask

    task automatic test_reset();
        nvdla_core_rstn = 1'b0;
        repeat (2) step();
        check_idle("reset_state");
        nvdla_core_rstn = 1'b1;
        step();
        checks++;
        if (dma_rd_req_rdy !== 1'b1) begin
            errs++;
            $display("FAIL reset_release_rdy: got %b required 1", dma_rd_req_rdy);
        end
    endtask

    task automatic test_issue_order();
        issue(1'b1);
        issue(1'b0);
        issue(1'b1);
        issue(1'b0);
        step();
        checks++;
        if (dma_rd_outstanding !== 3'd4 || sdp2mcif_rd_req_valid !== 1'b0 ||
            sdp2cvif_rd_req_valid !== 1'b0) begin
            errs++;
            $display("FAIL issue_four: out=%0d vm=%b vc=%b required 4 0 0",
                dma_rd_outstanding, sdp2mcif_rd_req_valid, sdp2cvif_rd_req_valid);
        end
        respond_all(0);
        pop_all();
    endtask

    task automatic test_credit_full();
        bit t5;
        for (int i = 0; i < 4; i++) issue(1'($urandom_range(0, 1)));
        respond_all(0);
        t5 = 1'($urandom_range(0, 1));
        dma_rd_req_vld = 1'b1;
        dma_rd_req_ram_type = t5;
        dma_rd_req_pd = rand_req();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dma_rd_req_rdy !== 1'b0 || dma_rd_outstanding !== 3'd4) begin
                errs++;
                $display("FAIL full_block: rdy=%b out=%0d required 0 4",
                    dma_rd_req_rdy, dma_rd_outstanding);
            end
            step();
        end
        dma_rd_cdt_lat_fifo_pop = 1'b1;
        #1;
        checks++;
        if (dma_rd_req_rdy !== 1'b0) begin
            errs++;
            $display("FAIL full_pop_same: rdy=%b required 0", dma_rd_req_rdy);
        end
        step();
        dma_rd_cdt_lat_fifo_pop = 1'b0;
        model_out--;
        checks++;
        if (dma_rd_req_rdy !== 1'b1 ||
            sdp2mcif_rd_cdt_lat_fifo_pop !== del_q[0]) begin
            errs++;
            $display("FAIL full_pop_next: rdy=%b pm=%b required 1 %b",
                dma_rd_req_rdy, sdp2mcif_rd_cdt_lat_fifo_pop, del_q[0]);
        end
        void'(del_q.pop_front());
        step();
        dma_rd_req_vld = 1'b0;
        issued_q.push_back(t5);
        model_out++;
        checks++;
        if (dma_rd_outstanding !== 3'd4 ||
            (t5 ? sdp2mcif_rd_req_valid : sdp2cvif_rd_req_valid) !== 1'b1) begin
            errs++;
            $display("FAIL full_fifth: out=%0d port_vld=%b required 4 1",
                dma_rd_outstanding,
                t5 ? sdp2mcif_rd_req_valid : sdp2cvif_rd_req_valid);
        end
        respond_all(0);
        pop_all();
    endtask

    task automatic test_out_of_order();
        issue(1'b1);
        issue(1'b0);
        respond_all(3);
        pop_all();
    endtask

    task automatic test_pop_err();
        dma_rd_cdt_lat_fifo_pop = 1'b1;
        step();
        dma_rd_cdt_lat_fifo_pop = 1'b0;
        checks++;
        if (sdp2mcif_rd_cdt_lat_fifo_pop !== 1'b0 ||
            sdp2cvif_rd_cdt_lat_fifo_pop !== 1'b0 || dma_rd_err !== 1'b1) begin
            errs++;
            $display("FAIL err_set: pm=%b pc=%b err=%b required 0 0 1",
                sdp2mcif_rd_cdt_lat_fifo_pop, sdp2cvif_rd_cdt_lat_fifo_pop,
                dma_rd_err);
        end
        repeat (3) step();
        issue(1'b0);
        respond_all(0);
        pop_all();
        checks++;
        if (dma_rd_err !== 1'b1 || dma_rd_outstanding !== 3'd0) begin
            errs++;
            $display("FAIL err_sticky: err=%b out=%0d required 1 0",
                dma_rd_err, dma_rd_outstanding);
        end
    endtask

    task automatic test_wrap();
        nvdla_core_rstn = 1'b0;
        step();
        nvdla_core_rstn = 1'b1;
        step();
        clear_model();
        checks++;
        if (dma_rd_err !== 1'b0) begin
            errs++;
            $display("FAIL err_clear: got %b required 0", dma_rd_err);
        end
        for (int i = 0; i < 10; i++) begin
            issue(i[0] == 1'b0);
            respond_all(0);
            pop_all();
        end
        for (int b = 0; b < 8; b++) begin
            int n;
            n = $urandom_range(1, LD);
            for (int i = 0; i < n; i++) issue(1'($urandom_range(0, 1)));
            respond_all(0);
            pop_all();
        end
        issue(1'b1);
        issue(1'b0);
        nvdla_core_rstn = 1'b0;
        step();
        check_idle("reset_midstream");
        nvdla_core_rstn = 1'b1;
        clear_model();
        step();
        issue(1'b1);
        respond_all(0);
        pop_all();
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < LD; i++) issue(1'($urandom_range(0, 1)));
            respond_all(0);
            pop_all();
        end
    endtask

    initial begin
        test_reset();
        test_issue_order();
        test_credit_full();
        test_out_of_order();
        test_back_to_back();
        test_pop_err();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

endmodule
